// File: rtl/mem_ctrl.sv
// Line-granular backing memory on a shared tristate command/data bus. A READ returns a line
// as a burst after MEM_LATENCY cycles; a WRITE collects a burst, commits it, then acknowledges.
module mem_ctrl #(
  parameter int BUS_SIZE          = 16,
  parameter int MEM_ADDR_SIZE     = 19,
  parameter int CACHE_OFFSET_SIZE = 4,
  parameter int CACHE_LINE_SIZE   = 16,
  parameter int MEM_LATENCY       = 100
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [MEM_ADDR_SIZE-CACHE_OFFSET_SIZE-1:0] mem_address,
  inout  wire logic [BUS_SIZE-1:0]                   mem_data,
  inout  wire logic [1:0]                            mem_command
);

  localparam int LINE_ADDR_W = MEM_ADDR_SIZE - CACHE_OFFSET_SIZE;
  localparam int LINE_BITS   = CACHE_LINE_SIZE * 8;
  localparam int NUM_BEATS   = LINE_BITS / BUS_SIZE;
  localparam int BEAT_W      = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int NUM_LINES   = 1 << LINE_ADDR_W;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);
  localparam logic [7:0]        LAT_LOAD  = 8'(MEM_LATENCY - 1);

  localparam logic [1:0] CMD_NOP      = 2'd0;
  localparam logic [1:0] CMD_RESPONSE = 2'd1;
  localparam logic [1:0] CMD_READ     = 2'd2;
  localparam logic [1:0] CMD_WRITE    = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_BURST,
    WR_BURST,
    WR_WAIT,
    WR_RESP
  } state_t;

  state_t                   r_state;
  logic [7:0]               r_lat;
  logic [BEAT_W-1:0]        r_beat;
  logic [LINE_ADDR_W-1:0]   r_addr;
  logic [LINE_BITS-1:0]     r_line;
  logic [BUS_SIZE-1:0]      r_dataOut;
  logic [1:0]               r_cmdOut;
  logic                     r_dataOe;
  logic                     r_cmdOe;
  logic [LINE_BITS-1:0]     r_mem [NUM_LINES];

  logic [LINE_BITS-1:0]     w_memLine;
  logic [LINE_BITS-1:0]     w_wrLine;
  logic [BEAT_W-1:0]        w_nextBeat;
  logic                     w_commit;

  // Power-up content: byte at byte address a holds a[7:0] ^ a[15:8].
  function automatic logic [LINE_BITS-1:0] initLine(input logic [LINE_ADDR_W-1:0] lineAddr);
    logic [LINE_BITS-1:0]         v;
    logic [CACHE_OFFSET_SIZE-1:0] off;
    logic [15:0]                  byteAddr;
    v = '0;
    for (int i = 0; i < CACHE_LINE_SIZE; i++) begin
      off               = CACHE_OFFSET_SIZE'(i);
      byteAddr          = 16'({lineAddr, off});
      v[8*i +: 8]       = byteAddr[7:0] ^ byteAddr[15:8];
    end
    return v;
  endfunction

  // Storage keeps each line XORed with its power-up pattern, so zeroed storage reads as that pattern.
  assign w_memLine  = r_mem[r_addr] ^ initLine(r_addr);
  assign w_nextBeat = r_beat + 1'b1;
  assign w_commit   = !reset && (r_state == WR_BURST) && (r_beat == LAST_BEAT);

  always_comb begin
    w_wrLine = r_line;
    w_wrLine[int'(r_beat)*BUS_SIZE +: BUS_SIZE] = mem_data;
  end

  always_ff @(posedge clk) begin
    if (w_commit) begin
      r_mem[r_addr] <= w_wrLine ^ initLine(r_addr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_lat     <= '0;
      r_beat    <= '0;
      r_dataOe  <= 1'b0;
      r_cmdOe   <= 1'b0;
      r_cmdOut  <= CMD_NOP;
      r_dataOut <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_addr <= mem_address;
          if (mem_command == CMD_READ) begin
            r_state <= RD_WAIT;
            r_lat   <= LAT_LOAD;
          end else if (mem_command == CMD_WRITE) begin
            r_state <= WR_BURST;
            r_line  <= w_wrLine;
            r_beat  <= w_nextBeat;
          end
        end

        RD_WAIT: begin
          if (r_lat == 8'd0) begin
            r_state   <= RD_BURST;
            r_line    <= w_memLine;
            r_dataOut <= w_memLine[BUS_SIZE-1:0];
            r_cmdOut  <= CMD_RESPONSE;
            r_cmdOe   <= 1'b1;
            r_dataOe  <= 1'b1;
          end else begin
            r_lat <= r_lat - 8'd1;
          end
        end

        RD_BURST: begin
          if (r_beat == LAST_BEAT) begin
            r_state  <= IDLE;
            r_beat   <= '0;
            r_cmdOe  <= 1'b0;
            r_dataOe <= 1'b0;
            r_cmdOut <= CMD_NOP;
          end else begin
            r_beat    <= w_nextBeat;
            r_dataOut <= r_line[int'(w_nextBeat)*BUS_SIZE +: BUS_SIZE];
          end
        end

        WR_BURST: begin
          r_line <= w_wrLine;
          if (r_beat == LAST_BEAT) begin
            r_state <= WR_WAIT;
            r_beat  <= '0;
            r_lat   <= LAT_LOAD;
          end else begin
            r_beat <= w_nextBeat;
          end
        end

        WR_WAIT: begin
          if (r_lat == 8'd0) begin
            r_state  <= WR_RESP;
            r_cmdOut <= CMD_RESPONSE;
            r_cmdOe  <= 1'b1;
          end else begin
            r_lat <= r_lat - 8'd1;
          end
        end

        WR_RESP: begin
          r_state  <= IDLE;
          r_cmdOe  <= 1'b0;
          r_cmdOut <= CMD_NOP;
        end

        default: begin
          r_state  <= IDLE;
          r_beat   <= '0;
          r_cmdOe  <= 1'b0;
          r_dataOe <= 1'b0;
        end
      endcase
    end
  end

  assign mem_data    = r_dataOe ? r_dataOut : {BUS_SIZE{1'bz}};
  assign mem_command = r_cmdOe  ? r_cmdOut  : 2'bzz;

endmodule
